// File: rtl/decoded_bit_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : decoded_bit_packer
//  Purpose  : Re-serialises traceback words oldest-bit-first and packs them
//             into bytes on a valid/ready stream with a frame-end marker.
//  Revision : 1.0  initial release
// ============================================================================
module decoded_bit_packer #(
   parameter int W_TB_LEN = 6,
   parameter int W_HALF   = 32,
   parameter int W_FULL   = 64
) (
   input  logic                clk_i,
   input  logic                rst_sync_i,
   input  logic                tb_bits_valid_i,
   input  logic                decoding_end_i,
   input  logic [W_HALF-1:0]   half_tb_bits_i,
   input  logic [W_FULL-1:0]   full_tb_bits_i,
   input  logic [W_TB_LEN:0]   bit_num_i,
   output logic                in_ready_o,
   output logic                overflow_o,
   output logic [7:0]          byte_o,
   output logic                byte_valid_o,
   input  logic                byte_ready_i,
   output logic                byte_last_o,
   output logic [3:0]          byte_nbits_o,
   output logic [31:0]         frame_bits_o
);

   localparam logic [W_TB_LEN:0] c_full_bits = (W_TB_LEN+1)'(W_FULL);
   localparam logic [W_TB_LEN:0] c_half_bits = (W_TB_LEN+1)'(W_HALF);
   localparam logic [W_TB_LEN:0] c_rem_one   = (W_TB_LEN+1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PACK = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   state_t              state_q,      state_d;
   logic [W_FULL-1:0]   wreg_q,       wreg_d;
   logic [W_TB_LEN:0]   rem_q,        rem_d;
   logic [7:0]          acc_q,        acc_d;
   logic [3:0]          acc_cnt_q,    acc_cnt_d;
   logic                last_q,       last_d;
   logic                overflow_q,   overflow_d;
   logic [31:0]         frame_bits_q, frame_bits_d;

   logic [W_TB_LEN:0]   bit_num_sel;
   logic [W_FULL-1:0]   word_sel;
   logic [W_TB_LEN:0]   rem_nxt;
   logic [3:0]          cnt_nxt;
   logic                emit_active;
   logic                emit_last;

   // Select the word for the segment type and clamp the count to its width.
   always_comb begin
      bit_num_sel = bit_num_i;
      word_sel    = {{(W_FULL-W_HALF){1'b0}}, half_tb_bits_i};
      if (decoding_end_i) begin
         word_sel = full_tb_bits_i;
         if (bit_num_i > c_full_bits) begin
            bit_num_sel = c_full_bits;
         end
      end else if (bit_num_i > c_half_bits) begin
         bit_num_sel = c_half_bits;
      end
   end

   assign emit_active = (state_q == ST_EMIT);
   assign emit_last   = emit_active && last_q && (rem_q == '0);
   assign rem_nxt     = rem_q - c_rem_one;
   assign cnt_nxt     = acc_cnt_q + 4'd1;

   always_comb begin
      state_d      = state_q;
      wreg_d       = wreg_q;
      rem_d        = rem_q;
      acc_d        = acc_q;
      acc_cnt_d    = acc_cnt_q;
      last_d       = last_q;
      overflow_d   = overflow_q;
      frame_bits_d = frame_bits_q;

      if (tb_bits_valid_i && (state_q != ST_IDLE)) begin
         overflow_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (tb_bits_valid_i) begin
               wreg_d = word_sel;
               rem_d  = bit_num_sel;
               last_d = decoding_end_i;
               // An empty final word still closes the frame: flush a partial
               // byte or send a zero-length terminator.
               if (bit_num_sel == '0) begin
                  state_d = decoding_end_i ? ST_EMIT : ST_IDLE;
               end else begin
                  state_d = ST_PACK;
               end
            end
         end

         ST_PACK: begin
            acc_d[acc_cnt_q[2:0]] = wreg_q[0];
            wreg_d    = wreg_q >> 1;
            rem_d     = rem_nxt;
            acc_cnt_d = cnt_nxt;
            if ((cnt_nxt == 4'd8) || ((rem_nxt == '0) && last_q)) begin
               state_d = ST_EMIT;
            end else if (rem_nxt == '0) begin
               state_d = ST_IDLE;
            end
         end

         ST_EMIT: begin
            if (byte_ready_i) begin
               acc_d     = 8'd0;
               acc_cnt_d = 4'd0;
               state_d   = (rem_q != '0) ? ST_PACK : ST_IDLE;
               if (emit_last) begin
                  last_d       = 1'b0;
                  frame_bits_d = 32'd0;
               end else begin
                  frame_bits_d = frame_bits_q + {28'd0, acc_cnt_q};
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_sync_i) begin
         state_q      <= ST_IDLE;
         wreg_q       <= '0;
         rem_q        <= '0;
         acc_q        <= 8'd0;
         acc_cnt_q    <= 4'd0;
         last_q       <= 1'b0;
         overflow_q   <= 1'b0;
         frame_bits_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         wreg_q       <= wreg_d;
         rem_q        <= rem_d;
         acc_q        <= acc_d;
         acc_cnt_q    <= acc_cnt_d;
         last_q       <= last_d;
         overflow_q   <= overflow_d;
         frame_bits_q <= frame_bits_d;
      end
   end

   // Byte fields read as zero outside EMIT so the sink never sees stale data.
   assign in_ready_o   = (state_q == ST_IDLE);
   assign overflow_o   = overflow_q;
   assign byte_valid_o = emit_active;
   assign byte_o       = emit_active ? acc_q : 8'd0;
   assign byte_nbits_o = emit_active ? acc_cnt_q : 4'd0;
   assign byte_last_o  = emit_last;
   assign frame_bits_o = frame_bits_q;

   a_acc_cnt_range: assert property (@(posedge clk_i) disable iff (rst_sync_i)
      acc_cnt_q <= 4'd8);

   a_hold_when_stalled: assert property (@(posedge clk_i) disable iff (rst_sync_i)
      (byte_valid_o && !byte_ready_i) |=>
         (byte_valid_o && $stable(byte_o) && $stable(byte_nbits_o) && $stable(byte_last_o)));

endmodule
`default_nettype wire

// File: tb/tb_decoded_bit_packer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for decoded_bit_packer: directed words, expected bytes queued in a
// scoreboard and checked by an independent monitor at each handshake.
module tb_decoded_bit_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tb_valid = 1'b0;
   logic        dec_end = 1'b0;
   logic [31:0] half = '0;
   logic [63:0] full = '0;
   logic [6:0]  bit_num = '0;
   logic        byte_ready = 1'b1;

   logic        in_ready;
   logic        overflow;
   logic [7:0]  byte_d;
   logic        byte_valid;
   logic        byte_last;
   logic [3:0]  byte_nbits;
   logic [31:0] frame_bits;

   decoded_bit_packer #(.W_TB_LEN(6), .W_HALF(32), .W_FULL(64)) dut (
      .clk_i           (clk),
      .rst_sync_i      (rst),
      .tb_bits_valid_i (tb_valid),
      .decoding_end_i  (dec_end),
      .half_tb_bits_i  (half),
      .full_tb_bits_i  (full),
      .bit_num_i       (bit_num),
      .in_ready_o      (in_ready),
      .overflow_o      (overflow),
      .byte_o          (byte_d),
      .byte_valid_o    (byte_valid),
      .byte_ready_i    (byte_ready),
      .byte_last_o     (byte_last),
      .byte_nbits_o    (byte_nbits),
      .frame_bits_o    (frame_bits)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  b;
      logic [3:0]  n;
      logic        l;
      logic [31:0] f;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   tb_frame = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   function automatic void expect_byte(input logic [7:0] b, input logic [3:0] n, input logic l);
      exp_t e;
      e.b = b;
      e.n = n;
      e.l = l;
      e.f = tb_frame[31:0];
      exp_q.push_back(e);
      tb_frame += int'(n);
      if (l) tb_frame = 0;
   endfunction

   // Monitor: compares each handshaken byte and output stability under stall.
   initial begin
      logic       stalled;
      logic [7:0] p_b;
      logic [3:0] p_n;
      logic       p_l;
      exp_t       e;
      stalled = 1'b0;
      p_b = '0; p_n = '0; p_l = 1'b0;
      forever begin
         @(negedge clk);
         if (byte_valid && stalled)
            check("hold_stable", {byte_d, byte_nbits, byte_last}, {p_b, p_n, p_l});
         if (byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_byte: got byte 0x%0h nbits %0d last %0d, expected none",
                        byte_d, byte_nbits, byte_last);
            end else begin
               e = exp_q.pop_front();
               check("byte{data,nbits,last,frame}",
                     {byte_d, byte_nbits, byte_last, frame_bits}, {e.b, e.n, e.l, e.f});
            end
         end
         stalled = byte_valid && !byte_ready;
         p_b = byte_d;
         p_n = byte_nbits;
         p_l = byte_last;
      end
   end

   task automatic wait_idle();
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (in_ready) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL idle_timeout: in_ready still 0 after 500 cycles, expected 1");
      end
   endtask

   task automatic send(input logic e, input logic [31:0] h, input logic [63:0] f,
                       input logic [6:0] n);
      wait_idle();
      @(posedge clk); #1;
      tb_valid = 1'b1; dec_end = e; half = h; full = f; bit_num = n;
      @(posedge clk); #1;
      tb_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      wait_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic got;

      // Reset values
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_valid_last", {byte_valid, byte_last}, 64'd0);
      check("rst_byte_nbits", {byte_d, byte_nbits}, 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_frame_bits", 64'(frame_bits), 64'd0);

      // Single byte with latency and ready-return timing
      expect_byte(8'hA5, 4'd8, 1'b0);
      send(1'b0, 32'h0000_00A5, 64'd0, 7'd8);
      cyc = 0;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         cyc++;
         if (byte_valid) begin
            got = 1'b1;
            break;
         end
      end
      check("t1_valid_seen", 64'(got), 64'd1);
      check("t1_latency", 64'(cyc), 64'd9);
      check("t1_in_ready_in_emit", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("t1_in_ready_after", 64'(in_ready), 64'd1);

      // Carry across segments
      expect_byte(8'h53, 4'd8, 1'b0);
      send(1'b0, 32'h3, 64'd0, 7'd4);
      send(1'b0, 32'h5, 64'd0, 7'd4);
      drain();

      // Overflow during PACK, then reset mid-PACK together with a strobe
      send(1'b0, 32'hFF, 64'd0, 7'd8);
      @(posedge clk); #1;
      tb_valid = 1'b1; dec_end = 1'b0; half = 32'h11; bit_num = 7'd8;
      @(posedge clk); #1;
      tb_valid = 1'b0;
      @(negedge clk);
      check("ovf_set", 64'(overflow), 64'd1);
      check("ovf_busy", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1; tb_valid = 1'b1; half = 32'h77; bit_num = 7'd8;
      @(posedge clk); #1;
      rst = 1'b0; tb_valid = 1'b0;
      tb_frame = 0;
      @(negedge clk);
      check("rst2_in_ready", 64'(in_ready), 64'd1);
      check("rst2_valid", 64'(byte_valid), 64'd0);
      check("rst2_overflow", 64'(overflow), 64'd0);
      check("rst2_frame", 64'(frame_bits), 64'd0);
      repeat (12) @(negedge clk);
      check("rst2_still_idle", {in_ready, byte_valid}, 64'h2);

      // Clean final 8-bit word: the full byte itself carries last
      expect_byte(8'h3C, 4'd8, 1'b1);
      send(1'b1, 32'd0, 64'h3C, 7'd8);
      drain();
      check("t3c_frame_zero", 64'(frame_bits), 64'd0);

      // Full final word with 5 cycles of backpressure on the first byte
      @(posedge clk); #1 byte_ready = 1'b0;
      expect_byte(8'hEF, 4'd8, 1'b0);
      expect_byte(8'hCD, 4'd8, 1'b0);
      expect_byte(8'hAB, 4'd8, 1'b0);
      expect_byte(8'h89, 4'd8, 1'b0);
      expect_byte(8'h67, 4'd8, 1'b0);
      expect_byte(8'h45, 4'd8, 1'b0);
      expect_byte(8'h23, 4'd8, 1'b0);
      expect_byte(8'h01, 4'd8, 1'b1);
      send(1'b1, 32'd0, 64'h0123_4567_89AB_CDEF, 7'd64);
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (byte_valid) begin
            got = 1'b1;
            break;
         end
      end
      check("bp_valid_seen", 64'(got), 64'd1);
      repeat (5) @(posedge clk);
      #1 byte_ready = 1'b1;
      drain();
      check("full_frame_zero", 64'(frame_bits), 64'd0);

      // Partial final word
      expect_byte(8'hBC, 4'd8, 1'b0);
      expect_byte(8'h0A, 4'd4, 1'b1);
      send(1'b1, 32'd0, 64'hABC, 7'd12);
      drain();

      // Empty terminator
      expect_byte(8'h00, 4'd0, 1'b1);
      send(1'b1, 32'd0, 64'd0, 7'd0);
      drain();

      // Partial byte carried into an empty final word
      expect_byte(8'h03, 4'd4, 1'b1);
      send(1'b0, 32'h3, 64'd0, 7'd4);
      send(1'b1, 32'd0, 64'hFFFF, 7'd0);
      drain();

      // Over-range bit count clamps to the half width, then terminator
      expect_byte(8'hEF, 4'd8, 1'b0);
      expect_byte(8'hBE, 4'd8, 1'b0);
      expect_byte(8'hAD, 4'd8, 1'b0);
      expect_byte(8'hDE, 4'd8, 1'b0);
      expect_byte(8'h00, 4'd0, 1'b1);
      send(1'b0, 32'hDEAD_BEEF, 64'd0, 7'd100);
      send(1'b1, 32'd0, 64'd0, 7'd0);
      drain();
      check("end_overflow", 64'(overflow), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
